// File: rtl/activation_buffer.sv
// Gathers a serial frame of signed activations into a parallel array, tracking the
// running maximum during fill, and hands the frame downstream with valid/ready.
module activation_buffer #(
  parameter int NUM_ACTIVATIONS = 10,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] activations [0:NUM_ACTIVATIONS-1],
  output logic [3:0]                   max_index,
  output logic                         frame_err
);

  // state | meaning
  // FILL  | accepting beats into activations[wr_ptr], running max updated
  // HOLD  | complete frame presented, waiting for out_ready
  typedef enum logic {FILL, HOLD} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ACTIVATIONS - 1);

  state_t                  state;
  logic [3:0]              wr_ptr;
  logic signed [DATA_WIDTH-1:0] max_val;
  logic                    accept;
  logic                    early_last;
  logic                    new_max;

  assign in_ready   = rst_n && (state == FILL);
  assign out_valid  = (state == HOLD);
  assign accept     = in_valid && in_ready;
  assign early_last = in_last && (wr_ptr != LAST_IDX);
  assign new_max    = (wr_ptr == 4'd0) || (in_data > max_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      wr_ptr    <= 4'd0;
      max_val   <= '0;
      max_index <= 4'd0;
      frame_err <= 1'b0;
      for (int i = 0; i < NUM_ACTIVATIONS; i++) activations[i] <= '0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            if (early_last) begin
              // aborted frame: drop the beat and restart at index 0
              frame_err <= 1'b1;
              wr_ptr    <= 4'd0;
            end else begin
              activations[wr_ptr] <= in_data;
              if (new_max) begin
                max_val   <= in_data;
                max_index <= wr_ptr;
              end
              if (wr_ptr == LAST_IDX) begin
                state     <= HOLD;
                wr_ptr    <= 4'd0;
                frame_err <= !in_last;
              end else begin
                wr_ptr <= wr_ptr + 4'd1;
              end
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state  <= FILL;
            wr_ptr <= 4'd0;
          end
        end
        default: begin
          state  <= FILL;
          wr_ptr <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_activation_buffer.sv
// Randomized and directed checks of activation_buffer against a queue-based frame model.
module tb_activation_buffer;
  localparam int N  = 10;
  localparam int DW = 32;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 in_last = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [DW-1:0] activations [0:N-1];
  logic [3:0]           max_index;
  logic                 frame_err;

  activation_buffer #(.NUM_ACTIVATIONS(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .activations(activations), .max_index(max_index), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: beats collected in a queue, frame judged when it completes
  int m_q[$];
  int m_arr [N] = '{default: 0};
  bit m_hold = 1'b0;
  bit m_err = 1'b0;
  int m_maxidx = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_hold = 1'b0;
      m_err = 1'b0;
      m_maxidx = 0;
      foreach (m_arr[k]) m_arr[k] = 0;
    end else begin
      m_err = 1'b0;
      if (m_hold) begin
        if (out_ready) m_hold = 1'b0;
      end else if (in_valid) begin
        if (in_last && m_q.size() < N - 1) begin
          m_err = 1'b1;
          m_q.delete();
        end else begin
          m_q.push_back(int'(in_data));
          if (m_q.size() == N) begin
            m_err = !in_last;
            m_hold = 1'b1;
            m_maxidx = 0;
            for (int k = 0; k < N; k++) begin
              m_arr[k] = m_q[k];
              if (m_q[k] > m_q[m_maxidx]) m_maxidx = k;
            end
            m_q.delete();
          end
        end
      end
    end
  end

  task automatic compare_outputs();
    check("in_ready", 64'(in_ready), 64'(!m_hold && rst_n));
    check("out_valid", 64'(out_valid), 64'(m_hold));
    check("frame_err", 64'(frame_err), 64'(m_err));
    if (m_hold || !rst_n) begin
      check("max_index", 64'(max_index), 64'(m_maxidx));
      for (int k = 0; k < N; k++)
        check($sformatf("act[%0d]", k), 64'(activations[k]), 64'(m_arr[k]));
    end
  endtask

  task automatic step(input logic v, input int d, input logic l, input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    @(negedge clk);
    compare_outputs();
  endtask

  int frame_buf [16];

  // sends n beats from frame_buf, in_last on beat last_at (-1: never)
  task automatic send(input int n, input int last_at, input bit rnd);
    int i = 0;
    int budget = 300;
    bit v;
    bit acc;
    while (i < n && budget > 0) begin
      v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      acc = v && !m_hold;
      step(v, frame_buf[i], v && (i == last_at), rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (acc) i++;
      budget--;
    end
    if (budget == 0) check("send_timeout", 64'(i), 64'(n));
  endtask

  task automatic release_hold();
    int budget = 50;
    while (m_hold && budget > 0) begin
      step(1'b0, 0, 1'b0, 1'b1);
      budget--;
    end
    if (budget == 0) check("hold_timeout", 64'(m_hold), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals0 [10] = '{3, -1, 7, 2, 7, 0, -5, 1, 6, 4};
    repeat (3) @(negedge clk);
    compare_outputs();
    rst_n = 1'b1;
    step(1'b0, 0, 1'b0, 1'b1);

    // test-plan frame with a tie at 7
    for (int k = 0; k < N; k++) frame_buf[k] = vals0[k];
    send(N, N - 1, 1'b0);
    check("plan_maxidx", 64'(max_index), 64'd2);
    release_hold();

    // all negative, then all minimum value
    for (int k = 0; k < N; k++) frame_buf[k] = k - 10;
    send(N, N - 1, 1'b0);
    check("neg_maxidx", 64'(max_index), 64'd9);
    for (int k = 0; k < N; k++) frame_buf[k] = int'(32'h8000_0000);
    send(N, N - 1, 1'b0);
    check("min_maxidx", 64'(max_index), 64'd0);

    // backpressure with in_valid held high
    for (int k = 0; k < N; k++) frame_buf[k] = 100 - k;
    send(N, N - 1, 1'b0);
    for (int c = 0; c < 20; c++) step(1'b1, int'($urandom), 1'b0, 1'b0);
    step(1'b1, 55, 1'b0, 1'b1);
    for (int k = 0; k < N; k++) frame_buf[k] = (k == 5) ? 77 : k;
    send(N, N - 1, 1'b0);
    check("bp_next_maxidx", 64'(max_index), 64'd5);

    // early last on beat 4, then a clean ramp
    for (int k = 0; k < 5; k++) frame_buf[k] = 500 + k;
    send(5, 4, 1'b0);
    for (int k = 0; k < N; k++) frame_buf[k] = k;
    send(N, N - 1, 1'b0);
    check("ramp_maxidx", 64'(max_index), 64'd9);

    // no in_last on the final beat
    for (int k = 0; k < N; k++) frame_buf[k] = (k * 37) % 11 - 5;
    send(N, -1, 1'b0);
    release_hold();

    // reset mid-frame, then a fresh frame with no residue
    for (int k = 0; k < 6; k++) frame_buf[k] = (k == 3) ? 1000 : k;
    send(6, -1, 1'b0);
    #2 rst_n = 1'b0;
    #1 compare_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 0, 1'b0, 1'b1);
    for (int k = 0; k < N; k++) frame_buf[k] = k;
    send(N, N - 1, 1'b0);
    check("post_rst_maxidx", 64'(max_index), 64'd9);

    // randomized frames: gaps, random hold time, occasional framing errors
    for (int f = 0; f < 30; f++) begin
      int kind = $urandom_range(0, 5);
      for (int k = 0; k < N; k++)
        frame_buf[k] = ($urandom_range(0, 1) != 0) ? int'($urandom) : int'($urandom_range(0, 6)) - 3;
      if (kind == 0) send($urandom_range(1, N - 1), -2, 1'b1);
      else if (kind == 1) send(N, -1, 1'b1);
      else send(N, N - 1, 1'b1);
      if (kind == 0) begin
        int n = $urandom_range(1, N - 1);
        send(n, n - 1, 1'b1);
      end
    end
    release_hold();
    step(1'b0, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/activation_buffer.md
# activation_buffer

Collects a serially streamed output-layer frame of signed activations into a NUM_ACTIVATIONS-entry register array and tracks the running maximum and its index during fill. When the frame is complete, it presents the whole array plus max_index to the downstream classifier stage through a valid/ready handshake. It sits between the final layer's serial MAC output and the argmax/classification logic, and converts one-per-cycle producer traffic into the parallel array form that stage consumes.

## Interface
- NUM_ACTIVATIONS, default 10: entries per frame; 2..16.
- DATA_WIDTH, default 32: activation width, signed two's complement.

- clk, input, 1: single clock; all state on rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- in_valid, input, 1: in_data/in_last valid.
- in_ready, output, 1: buffer accepts a beat.
- in_data, input, DATA_WIDTH signed: one activation per accepted beat, index order 0 upward.
- in_last, input, 1: producer marks final beat of frame.
- out_valid, output, 1: complete frame held on outputs.
- out_ready, input, 1: downstream consumes frame.
- activations, output, NUM_ACTIVATIONS x DATA_WIDTH signed, unpacked [0:NUM_ACTIVATIONS-1]: buffered frame.
- max_index, output, 4: index of largest activation; lowest index on ties.
- frame_err, output, 1: one-cycle pulse on in_last/count mismatch.

## Operation
- Accept = in_valid && in_ready. Output transfer = out_valid && out_ready.
- Two-state FSM:
  - FILL: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Reset enters FILL with wr_ptr=0.
- FILL, accept with wr_ptr < N-1 and in_last=0:
  - activations[wr_ptr] <= in_data; wr_ptr increments.
  - Running max update:
    - wr_ptr==0: max_val <= in_data, max_index <= 0 unconditionally.
    - Otherwise, if in_data > max_val (strict signed compare): max_val <= in_data, max_index <= wr_ptr.
- FILL, accept with wr_ptr == N-1:
  - Write the entry and apply the max update as above.
  - Go to HOLD.
  - If in_last=0, pulse frame_err; the frame still completes normally.
- FILL, accept with wr_ptr < N-1 and in_last=1 (early last):
  - Frame aborted. Pulse frame_err.
  - wr_ptr <= 0; stay in FILL.
  - The beat is not written.
  - Array contents are don't-care until the next complete frame.
- HOLD:
  - activations and max_index are stable.
  - On out_ready, go to FILL and set wr_ptr <= 0.
  - Array contents persist until overwritten.
- max_val is internal, DATA_WIDTH signed. No arithmetic beyond compare, so no overflow cases.
- The compare is fully signed: 0x80000000 is the minimum, 0x7FFFFFFF the maximum.

## Timing
- Reset values while rst_n low: in_ready=0, out_valid=0, frame_err=0, max_index=0, all activations=0, state FILL, wr_ptr=0.
- in_ready is combinational from state and is forced to 0 while rst_n is low. It is 1 from the first clock after release.
- Latency: out_valid rises the cycle after the Nth accept. max_index is valid in that same cycle (registered, no extra stage).
- Minimum frame period is N+1 cycles: N accept cycles plus 1 HOLD cycle with out_ready=1. There is one mandatory bubble between frames, because in_ready=0 in HOLD even when out_ready=1.
- frame_err is registered: high exactly the cycle after the offending accept.
- out_ready held low: HOLD persists indefinitely with outputs frozen and in_ready=0 (backpressure).
- in_valid low during FILL: no state change; gaps are allowed anywhere in the frame.
- Reset mid-frame or mid-HOLD: immediate return to reset values. No partial frame is ever presented.

## Test plan
- Reset then N=10 beats [3,-1,7,2,7,0,-5,1,6,4] with in_last on beat 9, out_ready=1 → out_valid one cycle after beat 9, activations match, max_index=2 (tie at 7 keeps lower index), frame_err never set, in_ready=1 again the next cycle.
- All-negative frame [-10,-9,...,-1] then [0x80000000 ×10] → max_index=9, then max_index=0.
- Complete frame with out_ready=0 for 20 cycles and in_valid=1 throughout → in_ready=0, outputs stable, no beats consumed. Raise out_ready → transfer, FILL resumes, the next frame loads correctly.
- in_last on beat 4 → frame_err pulse one cycle later, no out_valid. A following clean 10-beat frame [0..9] → max_index=9.
- 10 beats without in_last → frame_err pulse and out_valid in the same cycle, data correct.
- rst_n low after beat 6 of a frame → all outputs zero asynchronously. After release, a fresh 10-beat frame gives the correct array with no residue of the aborted frame in max_index.
